rgb_flow_reshaper: RTL

Parametrised next-generation RGB565 frame reshaper. It reads a full frame of 16-bit RGB565 pixels from a single-port frame RAM with one-cycle read latency. It expands each pixel to 8-bit channels (R, G, B, optional luma Y) and writes them as a byte stream to a destination buffer, in either planar or interleaved order. It sits between the camera frame RAM and the 8-bit feature/preprocessing buffer, with a single start pulse per frame.

---
 rtl/rgb_reshaper_pkg.sv | 43 ++++
 rtl/rgb565_expand.sv | 12 +
 rtl/rgb_flow_reshaper.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/rgb_reshaper_pkg.sv
// Shared types and helpers for the RGB565 frame reshaper.
// Holds the FSM states, channel indices and pixel expansion.
package rgb_reshaper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;
  localparam logic [1:0] CH_Y = 2'd3;

  localparam logic [7:0] Y_KR = 8'd77;
  localparam logic [7:0] Y_KG = 8'd150;
  localparam logic [7:0] Y_KB = 8'd29;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] y;
  } rgb8_t;

  function automatic rgb8_t expand565(input logic [15:0] px);
    rgb8_t o;
    logic [17:0] acc;
    o.r = {px[15:11], px[15:13]};
    o.g = {px[10:5], px[10:9]};
    o.b = {px[4:0], px[4:2]};
    o.y = 8'd0;
    // weights sum to 256, so the sum tops out below 2^16
    acc = 18'(Y_KR) * 18'(o.r)
        + 18'(Y_KG) * 18'(o.g)
        + 18'(Y_KB) * 18'(o.b);
    o.y = acc[15:8];
    return o;
  endfunction

endpackage

// File: rtl/rgb565_expand.sv
// Combinational RGB565 to 8-bit R/G/B/Y expansion.
// No state; the reshaper top owns every register.
module rgb565_expand
  import rgb_reshaper_pkg::*;
(
  input  logic [15:0] px,
  output rgb8_t       pix
);

  assign pix = expand565(px);

endmodule

// File: rtl/rgb_flow_reshaper.sv
// Streams an RGB565 frame out as 8-bit channel bytes,
// in planar or interleaved order, one byte per cycle.
module rgb_flow_reshaper
  import rgb_reshaper_pkg::*;
#(
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int ADDR_W  = 20,
  parameter int PLANAR  = 1,
  parameter int GRAY_EN = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ena,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done
);

  localparam int NCH = 3 + GRAY_EN;
  localparam int N   = IMG_W * IMG_H;
  localparam int TOT = NCH * N;
  localparam logic [ADDR_W-1:0] P_LAST = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(TOT - 1);
  localparam logic [1:0] C_LAST = 2'(NCH - 1);

  state_t state, state_n;

  logic [1:0]  rc;
  logic [1:0]  ch1;
  logic [1:0]  wc;
  logic        s1;
  logic [15:0] hold;
  logic [15:0] src;
  rgb8_t       px8;
  logic [1:0]  wch;
  logic [7:0]  byte_sel;
  logic        wr_nxt;
  logic        p_wrap;
  logic        c_wrap;
  logic        last_rd;
  logic        last_wr;

  assign p_wrap  = (rd_addr == P_LAST);
  assign c_wrap  = (rc == C_LAST);
  assign last_rd = rd_en && p_wrap && (PLANAR == 0 || c_wrap);
  assign last_wr = wr_en && (wr_addr == W_LAST);

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (ena) state_n = RUN;
      RUN:   if (last_rd) state_n = DRAIN;
      DRAIN: if (last_wr) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // interleaved channels 1.. replay the held pixel
  assign src = (PLANAR != 0 || s1) ? rd_data : hold;

  rgb565_expand u_expand (
    .px  (src),
    .pix (px8)
  );

  assign wch    = (PLANAR != 0) ? ch1 : (s1 ? CH_R : wc);
  assign wr_nxt = s1 || (PLANAR == 0 && wc != 2'd0);

  always_comb begin
    byte_sel = px8.y;
    unique case (wch)
      CH_R:    byte_sel = px8.r;
      CH_G:    byte_sel = px8.g;
      CH_B:    byte_sel = px8.b;
      default: byte_sel = px8.y;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      rc      <= 2'd0;
      s1      <= 1'b0;
      ch1     <= 2'd0;
      wc      <= 2'd0;
      hold    <= 16'd0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'd0;
    end else begin
      s1    <= rd_en;
      ch1   <= rc;
      wr_en <= wr_nxt;
      if (s1) hold <= rd_data;
      if (wr_nxt) begin
        wr_data <= byte_sel;
        wr_addr <= wr_en ? wr_addr + ADDR_W'(1) : '0;
      end
      if (s1)                wc <= 2'd1;
      else if (wc == C_LAST) wc <= 2'd0;
      else if (wc != 2'd0)   wc <= wc + 2'd1;

      if (state == IDLE) begin
        rd_en   <= ena;
        rd_addr <= '0;
        rc      <= 2'd0;
      end else if (state == RUN) begin
        if (PLANAR != 0) begin
          rd_en   <= !last_rd;
          rd_addr <= p_wrap ? '0 : rd_addr + ADDR_W'(1);
          if (p_wrap) rc <= rc + 2'd1;
        end else begin
          rd_en <= c_wrap;
          rc    <= c_wrap ? 2'd0 : rc + 2'd1;
          if (rd_en) rd_addr <= p_wrap ? '0 : rd_addr + ADDR_W'(1);
        end
      end else begin
        rd_en   <= 1'b0;
        rd_addr <= '0;
        rc      <= 2'd0;
      end
    end
  end

endmodule
